// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory store buffer.
//   WORD_W        : data word width.
//   IDX_MAX_W     : widest possible word index (32-bit byte address >> 2).
//   sb_entry_t    : one store-buffer entry {word index, data}.
//   drain_state_t : drain FSM states.
package dmem_pkg;

    localparam int WORD_W    = 32;
    localparam int IDX_MAX_W = 30;

    // The index field is sized for the widest word address so the type does
    // not depend on the instantiating module's ADDR_W. Indices are stored
    // zero-extended, so the unused upper bits are constant and optimise away.
    typedef struct packed {
        logic [IDX_MAX_W-1:0] idx;
        logic [WORD_W-1:0]    data;
    } sb_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } drain_state_t;

endpackage

// File: rtl/dmem_store_buffer_sb_fifo.sv
// sb_fifo: circular store FIFO with a parallel address-match lookup port.
//   clk, reset     : clock, asynchronous active-low reset (pointers/count).
//   enq, enq_entry : push enq_entry at tail (caller guarantees not full).
//   pop            : drop the head entry (caller guarantees not empty).
//   head_entry     : oldest entry.
//   count          : occupied entries.
//   lookup_idx     : word index to search for.
//   lookup_hit     : some occupied entry matches lookup_idx.
//   lookup_data    : data of the youngest matching entry.
module sb_fifo
    import dmem_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enq,
    input  sb_entry_t            enq_entry,
    input  logic                 pop,
    output sb_entry_t            head_entry,
    output logic [CNT_W-1:0]     count,
    input  logic [IDX_MAX_W-1:0] lookup_idx,
    output logic                 lookup_hit,
    output logic [WORD_W-1:0]    lookup_data
);

    sb_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (enq && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !enq) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is not reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries_q[tail_q] <= enq_entry;
        end
    end

    assign head_entry = entries_q[head_q];
    assign count      = count_q;

    // Walk from oldest to youngest so a later match overrides an earlier one,
    // giving youngest-wins forwarding for duplicate addresses.
    always_comb begin
        logic [PTR_W-1:0] slot;
        slot        = '0;
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (entries_q[slot].idx == lookup_idx)) begin
                lookup_hit  = 1'b1;
                lookup_data = entries_q[slot].data;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: data memory behind a store FIFO with load forwarding.
// The array needs WR_LAT cycles per write; stores queue in the FIFO and a
// drain FSM commits them in order. Loads see pending stores first.
//   clk        : rising-edge clock.
//   reset      : asynchronous active-low reset.
//   memwrite   : store request this cycle.
//   aluout     : byte address for the load or store.
//   writedata  : store data.
//   readdata   : combinational load data.
//   stall      : FIFO full; a store this cycle is not accepted.
//   pending    : number of occupied FIFO entries.
//   misaligned : store with a non-word-aligned address (store is dropped).
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter int  ADDR_W = 10,
    parameter int  WR_LAT = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [31:0]      aluout,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             stall,
    output logic [CNT_W-1:0] pending,
    output logic             misaligned
);

    localparam int LAT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

    drain_state_t         state_q, state_d;
    logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0]     count;
    logic                 enq;
    logic                 pop;
    logic [ADDR_W-1:0]    word_idx;
    logic [IDX_MAX_W-1:0] word_idx_ext;
    sb_entry_t            enq_entry;
    sb_entry_t            head_entry;
    logic                 lookup_hit;
    logic [WORD_W-1:0]    lookup_data;
    logic [WORD_W-1:0]    mem_q [2**ADDR_W];
    logic                 unused_ok;

    // Upper address bits are simply truncated away.
    assign word_idx     = aluout[ADDR_W+1:2];
    assign word_idx_ext = IDX_MAX_W'(word_idx);

    assign misaligned = memwrite && (aluout[1:0] != 2'b00);
    // Stall looks only at the registered count; a commit this cycle does
    // not free a slot until the next one.
    assign stall      = (count == CNT_W'(DEPTH));
    assign enq        = memwrite && !stall && !misaligned;
    assign pending    = count;

    assign enq_entry.idx  = word_idx_ext;
    assign enq_entry.data = writedata;

    sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .enq         (enq),
        .enq_entry   (enq_entry),
        .pop         (pop),
        .head_entry  (head_entry),
        .count       (count),
        .lookup_idx  (word_idx_ext),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data)
    );

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count != '0) begin
                    state_d   = BUSY;
                    lat_cnt_d = LAT_W'(WR_LAT - 1);
                end
            end
            BUSY: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end else begin
                    pop = 1'b1;
                    // Entries left after this pop, including one arriving now.
                    if ((count > CNT_W'(1)) || enq) begin
                        lat_cnt_d = LAT_W'(WR_LAT - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Reset forces IDLE asynchronously, so pop is low and an in-flight
    // write is abandoned with the array word untouched.
    always_ff @(posedge clk) begin
        if (pop) begin
            mem_q[head_entry.idx[ADDR_W-1:0]] <= head_entry.data;
        end
    end

    assign readdata = lookup_hit ? lookup_data : mem_q[word_idx];

    assign unused_ok = ^{aluout, head_entry.idx};

endmodule
